// File: rtl/ooc_lfsr_stimulus_bank_if.sv
// ----------------------------------------------------------------------------
// ooc_lfsr_stimulus_bank_if
//   Bundles the control, stimulus, response and signature-readout signals of
//   the out-of-context stimulus/response harness.
//
//   Parameters : NUM_CH, CH_WIDTH  - stimulus bus is NUM_CH*CH_WIDTH bits
//                RESP_WIDTH        - compacted DUT response / signature width
//   Signals    : i_run, i_step, i_reseed        advance / reseed control
//                o_stim                         concatenated LFSR channels
//                i_resp                         DUT response to compact
//                o_signature                    live MISR value
//                i_sig_read, o_sig_bit,
//                o_sig_busy                     serial signature readout
//                o_adv_count                    advances since reset/reseed
//   Modports   : master - the wrapper / bench driving the harness
//                slave  - the harness itself
// ----------------------------------------------------------------------------
interface ooc_lfsr_stimulus_bank_if #(
    parameter int NUM_CH     = 5,
    parameter int CH_WIDTH   = 32,
    parameter int RESP_WIDTH = 64
);
    logic                         i_run;
    logic                         i_step;
    logic                         i_reseed;
    logic [NUM_CH*CH_WIDTH-1:0]   o_stim;
    logic [RESP_WIDTH-1:0]        i_resp;
    logic [RESP_WIDTH-1:0]        o_signature;
    logic                         i_sig_read;
    logic                         o_sig_bit;
    logic                         o_sig_busy;
    logic [31:0]                  o_adv_count;

    modport master (
        output i_run, i_step, i_reseed, i_resp, i_sig_read,
        input  o_stim, o_signature, o_sig_bit, o_sig_busy, o_adv_count
    );

    modport slave (
        input  i_run, i_step, i_reseed, i_resp, i_sig_read,
        output o_stim, o_signature, o_sig_bit, o_sig_busy, o_adv_count
    );
endinterface

// File: rtl/ooc_lfsr_stimulus_bank.sv
// ----------------------------------------------------------------------------
// ooc_lfsr_stimulus_bank
//   Stimulus/response harness for out-of-context builds of pipeline blocks.
//   NUM_CH Galois LFSR channels drive the DUT inputs; the DUT response is
//   compacted into a MISR whose value can be shifted out serially, MSB first.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - ooc_lfsr_stimulus_bank_if.slave (control, stimulus, response,
//              signature and serial readout signals)
// ----------------------------------------------------------------------------
module ooc_lfsr_stimulus_bank #(
    parameter int                    NUM_CH     = 5,
    parameter int                    CH_WIDTH   = 32,
    parameter logic [CH_WIDTH-1:0]   POLY       = CH_WIDTH'(32'h0040_0007),
    parameter int                    SEED_BASE  = 3,
    parameter int                    SEED_STEP  = 2,
    parameter int                    RESP_WIDTH = 64,
    parameter logic [RESP_WIDTH-1:0] RESP_POLY  = RESP_WIDTH'(64'h0000_0000_0000_001B),
    parameter int                    RESP_LAT   = 1
) (
    input logic                      clk,
    input logic                      reset,
    ooc_lfsr_stimulus_bank_if.slave  bus
);

    localparam int CNT_W = $clog2(RESP_WIDTH);

    typedef enum logic {
        RD_IDLE,
        RD_SHIFT
    } rd_state_t;

    function automatic logic [CH_WIDTH-1:0] seed_of(input int k);
        logic [CH_WIDTH-1:0] s;
        s = CH_WIDTH'(longint'(SEED_BASE) + longint'(k) * longint'(SEED_STEP));
        // An all-zero seed would lock the LFSR, so it is bumped to 1.
        if (s == '0) s = CH_WIDTH'(1);
        return s;
    endfunction

    function automatic logic [CH_WIDTH-1:0] ch_step(input logic [CH_WIDTH-1:0] x);
        return {x[CH_WIDTH-2:0], 1'b0} ^ (x[CH_WIDTH-1] ? POLY : '0);
    endfunction

    function automatic logic [RESP_WIDTH-1:0] resp_step(input logic [RESP_WIDTH-1:0] x);
        return {x[RESP_WIDTH-2:0], 1'b0} ^ (x[RESP_WIDTH-1] ? RESP_POLY : '0);
    endfunction

    logic adv;
    logic absorb;
    assign adv = bus.i_run | bus.i_step;

    // ------------------------------------------------------------------
    // Stimulus channels and advance counter
    // ------------------------------------------------------------------
    logic [CH_WIDTH-1:0] ch_q [NUM_CH];
    logic [31:0]         adv_count_q;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= seed_of(k);
            adv_count_q <= '0;
        end else if (bus.i_reseed) begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= seed_of(k);
            adv_count_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= ch_step(ch_q[k]);
            adv_count_q <= adv_count_q + 32'd1;
        end
    end

    logic [NUM_CH*CH_WIDTH-1:0] stim_flat;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stim_flat = '0;
        for (int k = 0; k < NUM_CH; k++) stim_flat[k*CH_WIDTH +: CH_WIDTH] = ch_q[k];
    end

    assign bus.o_stim      = stim_flat;
    assign bus.o_adv_count = adv_count_q;

    // ------------------------------------------------------------------
    // Response-latency alignment: absorb is adv delayed by RESP_LAT cycles
    // ------------------------------------------------------------------
    if (RESP_LAT == 0) begin : g_no_lat
        assign absorb = adv;
    end else begin : g_lat
        logic [RESP_LAT-1:0] adv_dly_q;

        // Reseed flushes the line so responses to pre-reseed stimulus are
        // never folded into the fresh signature.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)             adv_dly_q <= '0;
            else if (bus.i_reseed) adv_dly_q <= '0;
            else                   adv_dly_q <= (adv_dly_q << 1) | RESP_LAT'(adv);
        end

        assign absorb = adv_dly_q[RESP_LAT-1];
    end

    // ------------------------------------------------------------------
    // MISR
    // ------------------------------------------------------------------
    logic [RESP_WIDTH-1:0] sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             sig_q <= '0;
        else if (bus.i_reseed) sig_q <= '0;
        else if (absorb)       sig_q <= resp_step(sig_q) ^ bus.i_resp;
    end

    assign bus.o_signature = sig_q;

    // ------------------------------------------------------------------
    // Serial readout FSM (unaffected by reseed)
    // ------------------------------------------------------------------
    rd_state_t             state_q,    state_d;
    logic [RESP_WIDTH-1:0] snap_q,     snap_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic                  sig_bit_q,  sig_bit_d;
    logic                  sig_busy_q, sig_busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RD_IDLE;
            snap_q     <= '0;
            bit_cnt_q  <= '0;
            sig_bit_q  <= 1'b0;
            sig_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            bit_cnt_q  <= bit_cnt_d;
            sig_bit_q  <= sig_bit_d;
            sig_busy_q <= sig_busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        bit_cnt_d  = bit_cnt_q;
        sig_bit_d  = sig_bit_q;
        sig_busy_d = sig_busy_q;
        unique case (state_q)
            RD_IDLE: begin
                if (bus.i_sig_read) begin
                    // The MSB is presented straight away, so the snapshot is
                    // stored already shifted by one place.
                    state_d    = RD_SHIFT;
                    snap_d     = sig_q << 1;
                    bit_cnt_d  = CNT_W'(RESP_WIDTH - 1);
                    sig_bit_d  = sig_q[RESP_WIDTH-1];
                    sig_busy_d = 1'b1;
                end
            end
            RD_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    state_d    = RD_IDLE;
                    sig_bit_d  = 1'b0;
                    sig_busy_d = 1'b0;
                end else begin
                    sig_bit_d  = snap_q[RESP_WIDTH-1];
                    snap_d     = snap_q << 1;
                    bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign bus.o_sig_bit  = sig_bit_q;
    assign bus.o_sig_busy = sig_busy_q;

endmodule

// File: tb/tb_ooc_lfsr_stimulus_bank.sv
// ----------------------------------------------------------------------------
// tb_ooc_lfsr_stimulus_bank
//   Self-checking bench for ooc_lfsr_stimulus_bank in a small configuration
//   (2 x 8-bit channels, POLY 8'h1D, 8-bit MISR with RESP_POLY 8'h1D,
//   RESP_LAT 1). Hand-derived vector table, hand-written readout / reseed /
//   async-reset sequences, then randomized traffic against a queue-based
//   reference model.
// ----------------------------------------------------------------------------
module tb_ooc_lfsr_stimulus_bank;

    localparam int         NUM_CH     = 2;
    localparam int         CH_WIDTH   = 8;
    localparam int         RESP_WIDTH = 8;
    localparam int         RESP_LAT   = 1;
    localparam int         SEED_BASE  = 3;
    localparam int         SEED_STEP  = 2;
    localparam logic [7:0] POLY       = 8'h1D;
    localparam logic [7:0] RESP_POLY  = 8'h1D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ooc_lfsr_stimulus_bank_if #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .RESP_WIDTH(RESP_WIDTH)
    ) bus ();

    ooc_lfsr_stimulus_bank #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .POLY(POLY),
        .SEED_BASE(SEED_BASE), .SEED_STEP(SEED_STEP),
        .RESP_WIDTH(RESP_WIDTH), .RESP_POLY(RESP_POLY), .RESP_LAT(RESP_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic set_in(input logic run, input logic step, input logic reseed,
                          input logic rd, input logic [7:0] resp);
        bus.i_run      = run;
        bus.i_step     = step;
        bus.i_reseed   = reseed;
        bus.i_sig_read = rd;
        bus.i_resp     = resp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        run, step, reseed, rd;
        logic [7:0]  resp;
        logic [15:0] e_stim;
        logic [7:0]  e_sig;
        logic [31:0] e_cnt;
        logic        e_busy, e_bit;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic run, input logic step, input logic reseed, input logic rd,
                           input logic [7:0] resp, input logic [15:0] e_stim, input logic [7:0] e_sig,
                           input logic [31:0] e_cnt, input logic e_busy, input logic e_bit);
        vec_t v;
        v = '{run, step, reseed, rd, resp, e_stim, e_sig, e_cnt, e_busy, e_bit};
        vq.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Reference model: values derived with plain arithmetic, pending
    // absorbs kept in a queue, serial readout as a queue of bits.
    // ------------------------------------------------------------------
    logic [7:0]  m_ch [NUM_CH];
    logic [7:0]  m_sig;
    logic [31:0] m_cnt;
    bit          m_pend[$];
    bit          m_bits[$];
    logic        m_busy, m_bit;

    function automatic logic [7:0] gal(input logic [7:0] x, input logic [7:0] p);
        int doubled;
        doubled = int'(x) * 2;
        return 8'(doubled % 256) ^ ((doubled >= 256) ? p : 8'h00);
    endfunction

    function automatic logic [7:0] seed(input int k);
        int s;
        s = (SEED_BASE + k * SEED_STEP) % 256;
        return (s == 0) ? 8'd1 : 8'(s);
    endfunction

    function automatic logic [15:0] m_stim();
        return {m_ch[1], m_ch[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_ch[k] = seed(k);
        m_sig = 8'h00;
        m_cnt = 32'd0;
        m_pend.delete();
        for (int i = 0; i < RESP_LAT; i++) m_pend.push_back(1'b0);
        m_bits.delete();
        m_busy = 1'b0;
        m_bit  = 1'b0;
    endtask

    task automatic model_edge(input logic run, input logic step, input logic reseed,
                              input logic rd, input logic [7:0] resp);
        bit         adv_now, absorb_now;
        logic [7:0] old_sig;
        adv_now    = run | step;
        absorb_now = (RESP_LAT == 0) ? adv_now : m_pend[0];
        old_sig    = m_sig;
        if (!m_busy) begin
            if (rd) begin
                m_bits.delete();
                for (int i = 7; i >= 0; i--) m_bits.push_back(old_sig[i]);
                m_bit  = m_bits.pop_front();
                m_busy = 1'b1;
            end
        end else if (m_bits.size() == 0) begin
            m_busy = 1'b0;
            m_bit  = 1'b0;
        end else begin
            m_bit = m_bits.pop_front();
        end
        if (reseed) begin
            for (int k = 0; k < NUM_CH; k++) m_ch[k] = seed(k);
            m_sig = 8'h00;
            m_cnt = 32'd0;
            for (int i = 0; i < RESP_LAT; i++) m_pend[i] = 1'b0;
        end else begin
            if (adv_now) begin
                for (int k = 0; k < NUM_CH; k++) m_ch[k] = gal(m_ch[k], POLY);
                m_cnt = m_cnt + 32'd1;
            end
            if (absorb_now) m_sig = gal(m_sig, RESP_POLY) ^ resp;
            if (RESP_LAT > 0) begin
                void'(m_pend.pop_front());
                m_pend.push_back(adv_now);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected end before 200000", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        vec_t       v;

        // ---------------- reset state ----------------
        reset = 1'b1;
        set_in(0, 0, 0, 0, 8'h00);
        tick();
        tick();
        check("reset.stim",  64'(bus.o_stim),      64'h0503);
        check("reset.sig",   64'(bus.o_signature), 64'h00);
        check("reset.count", 64'(bus.o_adv_count), 64'd0);
        check("reset.busy",  64'(bus.o_sig_busy),  64'd0);
        check("reset.bit",   64'(bus.o_sig_bit),   64'd0);
        reset = 1'b0;
        tick();
        check("release.stim", 64'(bus.o_stim), 64'h0503);

        // ---------------- vector table ----------------
        //       run st rs rd resp   stim     sig    cnt busy bit
        add_vec(1, 0, 0, 0, 8'h01, 16'h0A06, 8'h00, 1, 0, 0);
        add_vec(1, 0, 0, 0, 8'h01, 16'h140C, 8'h01, 2, 0, 0);
        add_vec(0, 0, 0, 0, 8'h01, 16'h140C, 8'h03, 2, 0, 0);
        add_vec(0, 0, 1, 0, 8'h01, 16'h0503, 8'h00, 0, 0, 0);
        add_vec(0, 1, 0, 0, 8'h00, 16'h0A06, 8'h00, 1, 0, 0);
        add_vec(0, 0, 0, 0, 8'h00, 16'h0A06, 8'h00, 1, 0, 0);
        add_vec(0, 1, 0, 0, 8'h00, 16'h140C, 8'h00, 2, 0, 0);
        add_vec(0, 0, 0, 0, 8'h00, 16'h140C, 8'h00, 2, 0, 0);
        add_vec(0, 1, 0, 0, 8'h00, 16'h2818, 8'h00, 3, 0, 0);
        add_vec(0, 0, 0, 0, 8'h00, 16'h2818, 8'h00, 3, 0, 0);
        add_vec(1, 1, 0, 0, 8'h00, 16'h5030, 8'h00, 4, 0, 0);
        add_vec(1, 1, 0, 0, 8'h00, 16'hA060, 8'h00, 5, 0, 0);
        add_vec(0, 0, 0, 0, 8'h00, 16'hA060, 8'h00, 5, 0, 0);
        add_vec(1, 0, 0, 0, 8'h00, 16'h5DC0, 8'h00, 6, 0, 0);
        add_vec(1, 0, 0, 0, 8'hA5, 16'hBA9D, 8'hA5, 7, 0, 0);
        add_vec(0, 0, 0, 1, 8'h00, 16'hBA9D, 8'h57, 7, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            set_in(v.run, v.step, v.reseed, v.rd, v.resp);
            tick();
            check($sformatf("vec%0d.stim", i),  64'(bus.o_stim),      64'(v.e_stim));
            check($sformatf("vec%0d.sig", i),   64'(bus.o_signature), 64'(v.e_sig));
            check($sformatf("vec%0d.count", i), 64'(bus.o_adv_count), 64'(v.e_cnt));
            check($sformatf("vec%0d.busy", i),  64'(bus.o_sig_busy),  64'(v.e_busy));
            check($sformatf("vec%0d.bit", i),   64'(bus.o_sig_bit),   64'(v.e_bit));
        end

        // ---------------- readout of 8'hA5, re-read at cycle 3 ignored ----------------
        pat = 8'hA5;
        for (int c = 1; c < 8; c++) begin
            set_in(0, 0, 0, (c == 3), 8'h00);
            tick();
            check($sformatf("rd_a5.busy%0d", c), 64'(bus.o_sig_busy), 64'd1);
            check($sformatf("rd_a5.bit%0d", c),  64'(bus.o_sig_bit),  64'(pat[7-c]));
        end
        set_in(0, 0, 0, 0, 8'h00);
        tick();
        check("rd_a5.done_busy", 64'(bus.o_sig_busy),  64'd0);
        check("rd_a5.done_bit",  64'(bus.o_sig_bit),   64'd0);
        check("rd_a5.sig_live",  64'(bus.o_signature), 64'h57);
        tick();
        check("rd_a5.no_restart", 64'(bus.o_sig_busy), 64'd0);

        // ---------------- reseed with pending absorb during readout ----------------
        pat = 8'h57;
        set_in(1, 0, 0, 1, 8'h00);
        tick();
        check("rsd.pre_stim",  64'(bus.o_stim),      64'h6927);
        check("rsd.pre_count", 64'(bus.o_adv_count), 64'd8);
        check("rsd.bit7",      64'(bus.o_sig_bit),   64'(pat[7]));
        set_in(1, 0, 1, 0, 8'hFF);
        tick();
        check("rsd.stim",  64'(bus.o_stim),      64'h0503);
        check("rsd.sig",   64'(bus.o_signature), 64'h00);
        check("rsd.count", 64'(bus.o_adv_count), 64'd0);
        check("rsd.busy",  64'(bus.o_sig_busy),  64'd1);
        check("rsd.bit6",  64'(bus.o_sig_bit),   64'(pat[6]));
        set_in(0, 0, 0, 0, 8'hFF);
        tick();
        check("rsd.dropped_absorb", 64'(bus.o_signature), 64'h00);
        check("rsd.bit5",           64'(bus.o_sig_bit),   64'(pat[5]));
        for (int c = 3; c < 8; c++) begin
            tick();
            check($sformatf("rsd.busy%0d", c), 64'(bus.o_sig_busy), 64'd1);
            check($sformatf("rsd.bit%0d", c),  64'(bus.o_sig_bit),  64'(pat[7-c]));
        end
        tick();
        check("rsd.done_busy", 64'(bus.o_sig_busy), 64'd0);

        // ---------------- async reset mid-readout ----------------
        set_in(1, 0, 0, 1, 8'h3C);
        tick();
        set_in(1, 0, 0, 0, 8'h3C);
        tick();
        check("arst.pre_busy", 64'(bus.o_sig_busy),  64'd1);
        check("arst.pre_sig",  64'(bus.o_signature), 64'h3C);
        check("arst.pre_cnt",  64'(bus.o_adv_count), 64'd2);
        set_in(0, 0, 0, 0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check("arst.busy",  64'(bus.o_sig_busy),  64'd0);
        check("arst.bit",   64'(bus.o_sig_bit),   64'd0);
        check("arst.stim",  64'(bus.o_stim),      64'h0503);
        check("arst.sig",   64'(bus.o_signature), 64'h00);
        check("arst.count", 64'(bus.o_adv_count), 64'd0);
        tick();
        reset = 1'b0;
        model_reset();

        // ---------------- randomized traffic vs. reference model ----------------
        for (int n = 0; n < 600; n++) begin
            logic       r_run, r_step, r_rs, r_rd;
            logic [7:0] r_resp;
            r_run  = ($urandom_range(0, 1) == 0);
            r_step = ($urandom_range(0, 3) == 0);
            r_rs   = ($urandom_range(0, 39) == 0);
            r_rd   = ($urandom_range(0, 11) == 0);
            r_resp = 8'($urandom);
            set_in(r_run, r_step, r_rs, r_rd, r_resp);
            model_edge(r_run, r_step, r_rs, r_rd, r_resp);
            tick();
            check($sformatf("rnd%0d.stim", n),  64'(bus.o_stim),      64'(m_stim()));
            check($sformatf("rnd%0d.sig", n),   64'(bus.o_signature), 64'(m_sig));
            check($sformatf("rnd%0d.count", n), 64'(bus.o_adv_count), 64'(m_cnt));
            check($sformatf("rnd%0d.busy", n),  64'(bus.o_sig_busy),  64'(m_busy));
            check($sformatf("rnd%0d.bit", n),   64'(bus.o_sig_bit),   64'(m_bit));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
